// File: rtl/eth_arb_pkg.sv
// Shared types and defaults for the RGMII transmit arbiter.
package eth_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_GAP
  } arb_state_e;

  localparam int ETH_IFG_DEFAULT = 12;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin winner search over a request vector, starting just after last_grant.
module rr_priority_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic             found,
  output logic [GW-1:0]    winner
);

  function automatic logic [GW-1:0] wrap_idx(input int unsigned v);
    return GW'(v % N_REQ);
  endfunction

  always_comb begin
    found  = 1'b0;
    winner = '0;
    // Walk from the farthest offset to the nearest so the nearest requester overwrites.
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      if (req[wrap_idx(32'(last_grant) + i)]) begin
        found  = 1'b1;
        winner = wrap_idx(32'(last_grant) + i);
      end
    end
  end

endmodule

// File: rtl/rgmii_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one RGMII TX byte stream between N_REQ sources,
// with a programmable idle gap after every frame.
module rgmii_tx_arbiter
  import eth_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned IFG_CYCLES = ETH_IFG_DEFAULT,
  parameter int unsigned GW         = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ*8-1:0] s_tdata,
  input  logic [N_REQ-1:0]   s_tvalid,
  input  logic [N_REQ-1:0]   s_tlast,
  output logic [N_REQ-1:0]   s_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  localparam int unsigned GapW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLoad = (IFG_CYCLES > 0) ? GapW'(IFG_CYCLES - 1) : '0;

  arb_state_e      state_q;
  logic [GW-1:0]   grant_id_q;
  logic [GW-1:0]   last_grant_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            busy_q;

  logic            found;
  logic [GW-1:0]   winner;
  logic            frame_end;
  logic [7:0]      lane_data [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_data[g] = s_tdata[g*8 +: 8];
  end

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_picker (
    .req        (s_tvalid),
    .last_grant (last_grant_q),
    .found      (found),
    .winner     (winner)
  );

  // Zero-latency pass-through of the granted lane; everything else is held quiet.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == ARB_XFER) begin
      m_tdata              = lane_data[grant_id_q];
      m_tvalid             = s_tvalid[grant_id_q];
      m_tlast              = s_tlast[grant_id_q];
      s_tready[grant_id_q] = m_tready;
    end
  end

  assign frame_end = m_tvalid & m_tready & m_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      gap_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (found) begin
            grant_id_q   <= winner;
            last_grant_q <= winner;
            busy_q       <= 1'b1;
            state_q      <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (frame_end) begin
            if (IFG_CYCLES == 0) begin
              busy_q  <= 1'b0;
              state_q <= ARB_IDLE;
            end else begin
              gap_cnt_q <= GapLoad;
              state_q   <= ARB_GAP;
            end
          end
        end
        ARB_GAP: begin
          if (gap_cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ARB_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rgmii_tx_arbiter.sv
// Scoreboard bench for rgmii_tx_arbiter: one instance with a 12-cycle gap, one with no gap.
module tb_rgmii_tx_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    int  id;
    int  data;
    bit  last;
    int  at;
    int  gap;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sel = 1'b0;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic           m_tready = 1'b1;

  logic [N-1:0] a_s_tready, z_s_tready, act_s_tready;
  logic [7:0]   a_m_tdata, z_m_tdata, act_m_tdata;
  logic         a_m_tvalid, z_m_tvalid, act_m_tvalid;
  logic         a_m_tlast, z_m_tlast, act_m_tlast;
  logic [1:0]   a_grant, z_grant, act_grant;
  logic         a_busy, z_busy, act_busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_end = -1;
  int   act_ifg;
  exp_t exp_q [$];
  beat_t lane_q [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgmii_tx_arbiter #(.N_REQ(N), .IFG_CYCLES(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (a_s_tready),
    .m_tdata  (a_m_tdata),
    .m_tvalid (a_m_tvalid),
    .m_tlast  (a_m_tlast),
    .m_tready (m_tready),
    .grant_id (a_grant),
    .busy     (a_busy)
  );

  rgmii_tx_arbiter #(.N_REQ(N), .IFG_CYCLES(0)) dut_z (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (z_s_tready),
    .m_tdata  (z_m_tdata),
    .m_tvalid (z_m_tvalid),
    .m_tlast  (z_m_tlast),
    .m_tready (m_tready),
    .grant_id (z_grant),
    .busy     (z_busy)
  );

  assign act_s_tready = sel ? z_s_tready : a_s_tready;
  assign act_m_tdata  = sel ? z_m_tdata  : a_m_tdata;
  assign act_m_tvalid = sel ? z_m_tvalid : a_m_tvalid;
  assign act_m_tlast  = sel ? z_m_tlast  : a_m_tlast;
  assign act_grant    = sel ? z_grant    : a_grant;
  assign act_busy     = sel ? z_busy     : a_busy;
  assign act_ifg      = sel ? 0 : 12;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source model: each lane presents the head of its queue and pops on handshake.
  initial begin
    logic [N-1:0] hs;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    forever begin
      @(negedge clk);
      hs = s_tvalid & act_s_tready;
      @(posedge clk);
      #1;
      for (int l = 0; l < N; l++) begin
        if (hs[l] && lane_q[l].size() > 0) void'(lane_q[l].pop_front());
        if (lane_q[l].size() > 0) begin
          s_tvalid[l]       = 1'b1;
          s_tdata[l*8 +: 8] = lane_q[l][0].d;
          s_tlast[l]        = lane_q[l][0].l;
        end else begin
          s_tvalid[l]       = 1'b0;
          s_tdata[l*8 +: 8] = 8'h00;
          s_tlast[l]        = 1'b0;
        end
      end
    end
  end

  // Monitor: every offered beat is compared with the head of the expected queue.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (rst_n && act_m_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h grant %0d expected no beat",
                   act_m_tdata, act_grant);
        end else begin
          cur = exp_q[0];
          chk("grant_id", 32'(act_grant), cur.id);
          chk("m_tdata", 32'(act_m_tdata), cur.data);
          chk("m_tlast", 32'(act_m_tlast), 32'(cur.last));
          if (m_tready) begin
            if (cur.at >= 0) chk("beat_cycle", cyc, cur.at);
            if (cur.gap >= 0) chk("ifg_spacing", cyc - last_end, cur.gap);
            if (cur.last) last_end = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic load_lane(input int lane, input int b0, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = 8'(b0 + i);
      b.l = (i == len - 1);
      lane_q[lane].push_back(b);
    end
  endtask

  task automatic expect_frame(input int lane, input int b0, input int len, input int at0,
                              input int gap);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.id   = lane;
      e.data = (b0 + i) & 8'hff;
      e.last = (i == len - 1);
      e.at   = (at0 < 0) ? -1 : at0 + i;
      e.gap  = (i == 0) ? gap : -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input logic s);
    sel      = s;
    rst_n    = 1'b0;
    m_tready = 1'b1;
    for (int l = 0; l < N; l++) lane_q[l].delete();
    exp_q.delete();
    last_end = -1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(act_busy), 0);
    chk("rst_m_tvalid", 32'(act_m_tvalid), 0);
    chk("rst_grant_id", 32'(act_grant), 0);
    chk("rst_s_tready", 32'(act_s_tready), 0);
    chk("rst_m_tdata", 32'(act_m_tdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (act_ifg + 4) @(posedge clk);
    #2;
    chk({name, "_idle_busy"}, 32'(act_busy), 0);
  endtask

  initial begin
    int k;
    #200us;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Single requester, first beat one cycle after valid, five consecutive beats.
    do_reset(1'b0);
    load_lane(0, 8'h11, 5);
    c = -1;
    for (int k = 0; k < 10 && c < 0; k++) begin
      @(posedge clk);
      #2;
      if (s_tvalid[0]) c = cyc;
    end
    expect_frame(0, 8'h11, 5, (c < 0) ? -1 : c + 1, -1);
    wait_drain("single", 40);

    // All four requesting continuously: 0,1,2,3,0 with 13 idle cycles between frames.
    do_reset(1'b0);
    expect_frame(0, 8'h01, 2, -1, -1);
    expect_frame(1, 8'h21, 2, -1, 14);
    expect_frame(2, 8'h31, 2, -1, 14);
    expect_frame(3, 8'h41, 2, -1, 14);
    expect_frame(0, 8'h05, 2, -1, 14);
    load_lane(0, 8'h01, 2);
    load_lane(0, 8'h05, 2);
    load_lane(1, 8'h21, 2);
    load_lane(2, 8'h31, 2);
    load_lane(3, 8'h41, 2);
    wait_drain("rr_order", 150);

    // Requester 2 with backpressure toggling every cycle.
    do_reset(1'b0);
    expect_frame(2, 8'h51, 4, -1, -1);
    load_lane(2, 8'h51, 4);
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      if (act_m_tvalid) chk("s_tready_mirror", 32'(act_s_tready), m_tready ? 32'h4 : 32'h0);
      @(posedge clk);
      #1;
      m_tready = ~m_tready;
    end
    m_tready = 1'b1;
    wait_drain("stall", 20);

    // No preemption: requester 0 arrives while requester 1 is mid-frame.
    do_reset(1'b0);
    expect_frame(1, 8'h61, 4, -1, -1);
    expect_frame(0, 8'h71, 2, -1, 14);
    load_lane(1, 8'h61, 4);
    repeat (3) @(posedge clk);
    #2;
    load_lane(0, 8'h71, 2);
    wait_drain("no_preempt", 60);

    // Asynchronous reset on byte 3 of 8, then requester 0 wins first.
    do_reset(1'b0);
    expect_frame(2, 8'h81, 8, -1, -1);
    load_lane(2, 8'h81, 8);
    c = 0;
    for (int k = 0; k < 20 && c == 0; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 6) c = 1;
    end
    chk("byte3_offered", 32'(act_m_tdata), 32'h83);
    rst_n = 1'b0;
    #1;
    chk("async_m_tvalid", 32'(act_m_tvalid), 0);
    chk("async_busy", 32'(act_busy), 0);
    chk("async_grant_id", 32'(act_grant), 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    for (int l = 0; l < N; l++) lane_q[l].delete();
    last_end = -1;
    expect_frame(0, 8'h91, 2, -1, -1);
    expect_frame(2, 8'hA1, 2, -1, 14);
    load_lane(2, 8'hA1, 2);
    load_lane(0, 8'h91, 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("after_reset", 60);

    // Zero gap: one idle cycle between back-to-back frames.
    do_reset(1'b1);
    expect_frame(0, 8'hB1, 2, -1, -1);
    expect_frame(1, 8'hC1, 3, -1, 2);
    load_lane(0, 8'hB1, 2);
    load_lane(1, 8'hC1, 3);
    wait_drain("zero_ifg", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
